// File: rtl/mult_stage_folded_pkg.sv
// Shared types and defaults for the folded multiply stage.
// Build option: MULT_STAGE_ROUND_EN selects round-half-up instead of truncation.
package mult_stage_folded_pkg;

  localparam int W_WIDTH_DEF    = 19;
  localparam int P_WIDTH_DEF    = 10;
  localparam int PROD_WIDTH_DEF = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int fracDrop(
    input int wW,
    input int pW,
    input int oW
  );
    return wW + pW - oW;
  endfunction

endpackage

// File: rtl/mult_stage_folded_lane.sv
// One signed-weight x unsigned-pixel multiplier with fixed-point scaling.
// Build option: MULT_STAGE_ROUND_EN adds half an output LSB before the shift.
module mult_lane
  import mult_stage_folded_pkg::*;
#(
  parameter int W_WIDTH    = W_WIDTH_DEF,
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF
) (
  input  logic signed [W_WIDTH-1:0]    weight,
  input  logic        [P_WIDTH-1:0]    pixel,
  output logic        [PROD_WIDTH-1:0] product
);

  localparam int FULL_W    = W_WIDTH + P_WIDTH;
  localparam int FRAC_DROP = fracDrop(W_WIDTH, P_WIDTH, PROD_WIDTH);

`ifdef MULT_STAGE_ROUND_EN
  localparam logic signed [FULL_W-1:0] ROUND_BIAS =
    FULL_W'(1) << (FRAC_DROP - 1);
`endif

  logic signed [FULL_W-1:0] fullProd;
  logic signed [FULL_W-1:0] biased;

  // pixel gets a zero sign bit so it multiplies as a positive value
  always_comb begin
    fullProd = FULL_W'(weight) * FULL_W'($signed({1'b0, pixel}));
`ifdef MULT_STAGE_ROUND_EN
    biased   = fullProd + ROUND_BIAS;
`else
    biased   = fullProd;
`endif
    product  = PROD_WIDTH'(biased >>> FRAC_DROP);
  end

endmodule

// File: rtl/mult_stage_folded.sv
// Time-folded multiply stage: LANES products over LANES/MULTS cycles.
// Build option: MULT_STAGE_ROUND_EN (rounding in mult_lane).
module mult_stage_folded
  import mult_stage_folded_pkg::*;
#(
  parameter int LANES      = 28,
  parameter int MULTS      = 7,
  parameter int W_WIDTH    = W_WIDTH_DEF,
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        GlobalReset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*W_WIDTH-1:0]    WeightX,
  input  logic [LANES*P_WIDTH-1:0]    PixelX,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*PROD_WIDTH-1:0] Output_syn
);

  localparam int PASSES = LANES / MULTS;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PASSES - 1);

  if (LANES % MULTS != 0) begin : gCfgErr
    $error("mult_stage_folded: LANES must be a multiple of MULTS");
  end

  state_t state;
  state_t nextState;
  logic [CNT_W-1:0] passCnt;
  logic load;
  logic step;

  logic [PASSES-1:0][MULTS-1:0][W_WIDTH-1:0]    weightReg;
  logic [PASSES-1:0][MULTS-1:0][P_WIDTH-1:0]    pixelReg;
  logic [PASSES-1:0][MULTS-1:0][PROD_WIDTH-1:0] outBuf;
  logic [MULTS-1:0][PROD_WIDTH-1:0]             laneProd;

  // the pass counter picks which group of lanes feeds the multipliers
  for (genvar m = 0; m < MULTS; m++) begin : gLane
    mult_lane #(
      .W_WIDTH   (W_WIDTH),
      .P_WIDTH   (P_WIDTH),
      .PROD_WIDTH(PROD_WIDTH)
    ) uLane (
      .weight (weightReg[passCnt][m]),
      .pixel  (pixelReg[passCnt][m]),
      .product(laneProd[m])
    );
  end

  // next state and handshake outputs
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (passCnt == LAST) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            nextState = RUN;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // state register and pass counter
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state   <= IDLE;
      passCnt <= '0;
    end else begin
      state <= nextState;
      if (load) begin
        passCnt <= '0;
      end else if (step) begin
        passCnt <= (passCnt == LAST) ? '0 : passCnt + 1'b1;
      end
    end
  end

  // operand capture on accept
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      weightReg <= '0;
      pixelReg  <= '0;
    end else if (load) begin
      weightReg <= WeightX;
      pixelReg  <= PixelX;
    end
  end

  // one output slice per pass; other slices keep old contents
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      outBuf <= '0;
    end else if (step) begin
      outBuf[passCnt] <= laneProd;
    end
  end

  assign Output_syn = outBuf;

endmodule

// File: tb/tb_mult_stage_folded.sv
// Self-checking bench for mult_stage_folded.
// Honours MULT_STAGE_ROUND_EN for the expected values.
module tb_mult_stage_folded;

  localparam int LANES = 28;
  localparam int WW    = 19;
  localparam int PW    = 10;
  localparam int OW    = 26;
  localparam int FRAC  = WW + PW - OW;
`ifdef MULT_STAGE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef logic [LANES*OW-1:0] vec_t;

  typedef struct {
    string nm;
    int    w0;
    int    wInc;
    int    pix;
    int    e0;
    int    eInc;
  } vecRec_t;

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [LANES*WW-1:0] WeightX = '0;
  logic [LANES*PW-1:0] PixelX = '0;

  logic in_ready, out_valid;
  logic in_ready14, out_valid14;
  logic in_ready28, out_valid28;
  vec_t Output_syn, out14, out28;

  int checks = 0;
  int errors = 0;
  int wv[LANES];
  int pv[LANES];
  vecRec_t tbl[8];
  vec_t q[$];

  always #5 clk = ~clk;

  mult_stage_folded dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready),
    .WeightX(WeightX), .PixelX(PixelX),
    .out_valid(out_valid), .out_ready(out_ready),
    .Output_syn(Output_syn)
  );

  mult_stage_folded #(.MULTS(14)) u14 (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready14),
    .WeightX(WeightX), .PixelX(PixelX),
    .out_valid(out_valid14), .out_ready(out_ready),
    .Output_syn(out14)
  );

  mult_stage_folded #(.MULTS(28)) u28 (
    .clk(clk), .GlobalReset(GlobalReset),
    .in_valid(in_valid), .in_ready(in_ready28),
    .WeightX(WeightX), .PixelX(PixelX),
    .out_valid(out_valid28), .out_ready(out_ready),
    .Output_syn(out28)
  );

  function automatic longint refLane(input int w, input int p);
    longint full;
    full = longint'(w) * longint'(p);
    if (RND) full = full + (longint'(1) << (FRAC - 1));
    return full >>> FRAC;
  endfunction

  function automatic vec_t refVec();
    vec_t v;
    for (int k = 0; k < LANES; k++)
      v[k*OW +: OW] = OW'(refLane(wv[k], pv[k]));
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkVec(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < LANES; k++) begin
        if (act[k*OW +: OW] !== exp[k*OW +: OW]) begin
          $display("FAIL %s: lane %0d got %0d expected %0d", nm, k,
                   $signed(act[k*OW +: OW]), $signed(exp[k*OW +: OW]));
          break;
        end
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < LANES; k++) begin
      WeightX[k*WW +: WW] = WW'(wv[k]);
      PixelX[k*PW +: PW]  = PW'(pv[k]);
    end
  endtask

  task automatic loadRec(input vecRec_t r, output vec_t ev);
    for (int k = 0; k < LANES; k++) begin
      wv[k] = r.w0 + k * r.wInc;
      pv[k] = r.pix;
      ev[k*OW +: OW] = OW'(r.e0 + k * r.eInc);
    end
    drive();
  endtask

  // call at a negedge; returns just after the accepting posedge
  task automatic acceptOne(input string nm);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk({nm, " accept timeout"}, 0, 1);
  endtask

  task automatic runRec(input vecRec_t r);
    vec_t ev;
    int lat;
    bit rdyBad;
    lat = -1;
    rdyBad = 1'b0;
    @(negedge clk);
    loadRec(r, ev);
    out_ready = 1'b0;
    acceptOne(r.nm);
    for (int c = 1; c <= 6; c++) begin
      if (!out_valid && in_ready) rdyBad = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid && lat < 0) lat = c;
    end
    chk({r.nm, " latency"}, lat, 4);
    chk({r.nm, " in_ready in RUN"}, rdyBad, 0);
    checkVec(r.nm, Output_syn, ev);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({r.nm, " idle out_valid"}, out_valid, 0);
    chk({r.nm, " idle in_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ev, evB, held;
    bit bad, acc;
    int lat7, lat14, lat28;

    tbl[0] = '{"neg5x7",   -5,      0, 7,    RND ? -4 : -5, 0};
    tbl[1] = '{"laneOrd",  1,       1, 8,    1,             1};
    tbl[2] = '{"minW",     -262144, 0, 1023, -33521664,     0};
    tbl[3] = '{"maxW",     262143,  0, 1023, 33521536,      0};
    tbl[4] = '{"neg1x1",   -1,      0, 1,    RND ? 0 : -1,  0};
    tbl[5] = '{"pos4x1",   4,       0, 1,    RND ? 1 : 0,   0};
    tbl[6] = '{"neg4x1",   -4,      0, 1,    RND ? 0 : -1,  0};
    tbl[7] = '{"zeroPix",  -77,     3, 0,    0,             0};

    // reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    GlobalReset = 1'b0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset Output_syn", longint'(Output_syn != '0), 0);
    chk("reset in_ready", in_ready, 1);

    foreach (tbl[i]) runRec(tbl[i]);

    // backpressure then back-to-back accept
    @(negedge clk);
    loadRec(tbl[1], ev);
    acceptOne("bp");
    bad = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        bad = 1'b0;
        break;
      end
    end
    chk("bp out_valid timeout", bad, 0);
    held = Output_syn;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (Output_syn !== held || in_ready || !out_valid) bad = 1'b1;
    end
    chk("bp hold stable", bad, 0);
    checkVec("bp held data", held, ev);
    @(negedge clk);
    loadRec(tbl[0], evB);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp in_ready follows out_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b out_valid drops", out_valid, 0);
    chk("b2b in_ready in RUN", in_ready, 0);
    @(posedge clk);
    #1;
    chk("b2b lane0 new", $signed(Output_syn[0 +: OW]), RND ? -4 : -5);
    chk("b2b lane27 old", $signed(Output_syn[27*OW +: OW]), 28);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b out_valid", out_valid, 1);
    checkVec("b2b data", Output_syn, evB);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // randomized traffic against a queue model
    acc = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (cyc >= 400) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end else begin
        if (!in_valid || acc) begin
          in_valid = ($urandom % 3) != 0;
          if (in_valid) begin
            for (int k = 0; k < LANES; k++) begin
              case ($urandom % 8)
                0: wv[k] = -262144;
                1: wv[k] = 262143;
                default: wv[k] = int'($signed(WW'($urandom)));
              endcase
              pv[k] = ($urandom % 8 == 0) ? 1023 : int'($urandom_range(0, 1023));
            end
            drive();
          end
        end
        out_ready = ($urandom % 4) != 0;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand unexpected output", 1, 0);
        else checkVec("rand data", Output_syn, q.pop_front());
      end
      if (acc) q.push_back(refVec());
    end
    chk("rand queue drained", q.size(), 0);

    // reset mid-RUN, then latency per fold factor
    @(negedge clk);
    loadRec(tbl[1], ev);
    out_ready = 1'b0;
    acceptOne("midrst");
    @(posedge clk);
    @(posedge clk);
    #2;
    GlobalReset = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst Output_syn", longint'(Output_syn != '0), 0);
    chk("midrst out14", longint'(out14 != '0 || out_valid14), 0);
    chk("midrst out28", longint'(out28 != '0 || out_valid28), 0);
    @(negedge clk);
    GlobalReset = 1'b0;
    #1;
    chk("midrst in_ready all", longint'({in_ready, in_ready14, in_ready28}), 7);
    @(negedge clk);
    loadRec(tbl[0], evB);
    acceptOne("fold");
    lat7 = -1;
    lat14 = -1;
    lat28 = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat7 < 0) lat7 = c;
      if (out_valid14 && lat14 < 0) lat14 = c;
      if (out_valid28 && lat28 < 0) lat28 = c;
    end
    chk("latency MULTS=7", lat7, 4);
    chk("latency MULTS=14", lat14, 2);
    chk("latency MULTS=28", lat28, 1);
    checkVec("fold data 7", Output_syn, evB);
    checkVec("fold data 14", out14, evB);
    checkVec("fold data 28", out28, evB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
